// File: rtl/cpu_trace_buf.sv
// rtl/cpu_trace_buf.sv - pipeline trace capture: circular record buffer, PC/kill trigger,
// post-trigger window, oldest-first readout over a req/valid port
module cpu_trace_buf #(
  parameter  int DEPTH = 16,
  parameter  int PC_W  = 32,
  parameter  int ST_W  = 35,
  localparam int AW    = $clog2(DEPTH),
  localparam int REC_W = PC_W + ST_W + 3
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             arm,
  input  logic             trig_pc_en,
  input  logic [PC_W-1:0]  trig_pc,
  input  logic             trig_kill_en,
  input  logic [AW:0]      post_len,
  input  logic [PC_W-1:0]  pc_1a,
  input  logic [PC_W-1:0]  pc_4a,
  input  logic             kill_4a,
  input  logic             stall_2a,
  input  logic             st__push_5a,
  input  logic [ST_W-1:0]  st__to_push_5a,
  input  logic             rd_req,
  output logic             rd_valid,
  output logic [REC_W-1:0] rd_data,
  output logic             rd_last,
  output logic [1:0]       state_o,
  output logic [AW-1:0]    trig_idx,
  output logic             wrapped
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    POST  = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POST_MAX = AW'(DEPTH - 1);

  state_t            state, state_next;
  logic [AW-1:0]     wr_ptr, wr_ptr_next;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     post_left, post_len_clamped;
  logic [AW:0]       count, count_next;
  logic [AW:0]       remaining;
  logic              wrapped_next;
  logic              cap, hit, trig_now, enter_done, rd_take;
  logic [REC_W-1:0]  record;
  logic [REC_W-1:0]  mem [DEPTH];

  // Only the low PC bit of stage 1 is part of the record.
  logic unused_pc_1a;
  assign unused_pc_1a = ^pc_1a[PC_W-1:1];

  assign record  = {pc_4a, kill_4a, st__push_5a, st__to_push_5a, pc_1a[0]};
  assign state_o = state;

  always_comb begin
    cap              = (state == ARMED || state == POST) && !stall_2a && !arm;
    hit              = (trig_pc_en && (pc_4a == trig_pc)) || (trig_kill_en && kill_4a);
    trig_now         = cap && (state == ARMED) && hit;
    rd_take          = (state == DONE) && rd_req && (remaining != '0) && !arm;
    post_len_clamped = (post_len > {1'b0, POST_MAX}) ? POST_MAX : post_len[AW-1:0];
    wr_ptr_next      = wr_ptr;
    count_next       = count;
    wrapped_next     = wrapped;
    if (arm) begin
      wr_ptr_next  = '0;
      count_next   = '0;
      wrapped_next = 1'b0;
    end else if (cap) begin
      wr_ptr_next  = wr_ptr + AW'(1);
      count_next   = (count == FULL) ? FULL : count + (AW+1)'(1);
      wrapped_next = wrapped || (count == FULL);
    end
  end

  always_comb begin
    state_next = state;
    enter_done = 1'b0;
    if (arm) begin
      state_next = ARMED;
    end else begin
      case (state)
        IDLE: state_next = IDLE;
        ARMED: begin
          if (trig_now) begin
            if (post_left == '0) begin
              state_next = DONE;
              enter_done = 1'b1;
            end else begin
              state_next = POST;
            end
          end
        end
        POST: begin
          if (cap && (post_left == AW'(1))) begin
            state_next = DONE;
            enter_done = 1'b1;
          end
        end
        DONE: begin
          // Leave one cycle after the final record is presented.
          if (rd_last) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (cap) mem[wr_ptr] <= record;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr    <= '0;
      count     <= '0;
      wrapped   <= 1'b0;
      post_left <= '0;
      trig_idx  <= '0;
      rd_ptr    <= '0;
      remaining <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      rd_data   <= '0;
    end else begin
      wr_ptr  <= wr_ptr_next;
      count   <= count_next;
      wrapped <= wrapped_next;

      if (arm)                        post_left <= post_len_clamped;
      else if (cap && state == POST)  post_left <= post_left - AW'(1);

      if (trig_now) trig_idx <= wr_ptr;

      // Once wrapped, the oldest surviving record sits at the next write slot.
      if (arm) begin
        rd_ptr    <= '0;
        remaining <= '0;
      end else if (enter_done) begin
        rd_ptr    <= wrapped_next ? wr_ptr_next : '0;
        remaining <= count_next;
      end else if (rd_take) begin
        rd_ptr    <= rd_ptr + AW'(1);
        remaining <= remaining - (AW+1)'(1);
      end

      rd_valid <= rd_take;
      rd_last  <= rd_take && (remaining == (AW+1)'(1));
      if (rd_take) rd_data <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_cpu_trace_buf.sv
// tb/tb_cpu_trace_buf.sv - scoreboard bench for cpu_trace_buf against a queue-based trace model
module tb_cpu_trace_buf;

  localparam int DEPTH = 16;
  localparam int PC_W  = 32;
  localparam int ST_W  = 35;
  localparam int AW    = 4;
  localparam int REC_W = PC_W + ST_W + 3;

  typedef logic [REC_W-1:0] rec_t;

  logic             clk = 1'b0;
  logic             rst_b;
  logic             arm;
  logic             trig_pc_en;
  logic [PC_W-1:0]  trig_pc;
  logic             trig_kill_en;
  logic [AW:0]      post_len;
  logic [PC_W-1:0]  pc_1a;
  logic [PC_W-1:0]  pc_4a;
  logic             kill_4a;
  logic             stall_2a;
  logic             st__push_5a;
  logic [ST_W-1:0]  st__to_push_5a;
  logic             rd_req;
  logic             rd_valid;
  logic [REC_W-1:0] rd_data;
  logic             rd_last;
  logic [1:0]       state_o;
  logic [AW-1:0]    trig_idx;
  logic             wrapped;

  cpu_trace_buf #(.DEPTH(DEPTH), .PC_W(PC_W), .ST_W(ST_W)) dut (
    .clk(clk), .rst_b(rst_b), .arm(arm), .trig_pc_en(trig_pc_en), .trig_pc(trig_pc),
    .trig_kill_en(trig_kill_en), .post_len(post_len), .pc_1a(pc_1a), .pc_4a(pc_4a),
    .kill_4a(kill_4a), .stall_2a(stall_2a), .st__push_5a(st__push_5a),
    .st__to_push_5a(st__to_push_5a), .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_last(rd_last), .state_o(state_o), .trig_idx(trig_idx), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_rd     = 0;

  // Model: whole trace history since arm (last DEPTH kept) plus mode bookkeeping.
  rec_t            m_hist[$];
  rec_t            m_rd_q[$];
  logic [REC_W:0]  exp_q[$];
  int              m_st, m_post, m_total, m_trig;
  bit              m_wr, m_last;
  logic [REC_W:0]  mon_e;

  task automatic check(input bit ok, input string name, input logic [REC_W:0] act, input logic [REC_W:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rd_last && !rd_valid) check(1'b0, "rd_last_without_valid", rd_last, 0);
    if (rd_valid) begin
      check(exp_q.size() != 0, "unexpected_rd_valid", rd_valid, 0);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check(rd_data == mon_e[REC_W-1:0], "rd_data", rd_data, mon_e[REC_W-1:0]);
        check(rd_last == mon_e[REC_W], "rd_last", rd_last, mon_e[REC_W]);
        n_rd++;
      end
    end
  end

  task automatic model_reset();
    m_hist.delete(); m_rd_q.delete();
    m_st = 0; m_post = 0; m_total = 0; m_trig = 0; m_wr = 0; m_last = 0;
  endtask

  // Apply current inputs to the model for the coming edge, clock, then compare state.
  task automatic step();
    rec_t r, dummy;
    bit cap, hit, take, old_last, done;
    int slot;
    r        = {pc_4a, kill_4a, st__push_5a, st__to_push_5a, pc_1a[0]};
    cap      = (m_st == 1 || m_st == 2) && !stall_2a && !arm;
    hit      = (trig_pc_en && pc_4a == trig_pc) || (trig_kill_en && kill_4a);
    take     = (m_st == 3) && rd_req && (m_rd_q.size() != 0) && !arm;
    old_last = m_last;
    m_last   = 0;
    done     = 0;
    if (arm) begin
      m_hist.delete(); m_rd_q.delete();
      m_total = 0; m_wr = 0; m_st = 1;
      m_post  = (int'(post_len) > DEPTH - 1) ? DEPTH - 1 : int'(post_len);
    end else if (cap) begin
      m_hist.push_back(r);
      if (m_hist.size() > DEPTH) begin
        dummy = m_hist.pop_front();
        m_wr  = 1;
      end
      slot = m_total % DEPTH;
      m_total++;
      if (m_st == 1 && hit) begin
        m_trig = slot;
        if (m_post == 0) done = 1;
        else m_st = 2;
      end else if (m_st == 2) begin
        m_post--;
        if (m_post == 0) done = 1;
      end
      if (done) begin
        m_st   = 3;
        m_rd_q = m_hist;
      end
    end else if (take) begin
      r      = m_rd_q.pop_front();
      m_last = (m_rd_q.size() == 0);
      exp_q.push_back({m_last, r});
    end else if (m_st == 3 && old_last) begin
      m_st = 0;
    end
    @(posedge clk);
    #1;
    check(state_o == m_st[1:0], "state", state_o, m_st[1:0]);
    check(wrapped == m_wr, "wrapped", wrapped, m_wr);
    if (m_st == 3) check(trig_idx == m_trig[AW-1:0], "trig_idx", trig_idx, m_trig[AW-1:0]);
  endtask

  task automatic rand_side();
    pc_1a          = $urandom;
    st__push_5a    = 1'($urandom);
    st__to_push_5a = ST_W'({$urandom, $urandom});
    kill_4a        = 1'($urandom);
    pc_4a          = $urandom;
    stall_2a       = 1'($urandom);
    rd_req         = 1'($urandom);
  endtask

  // Trigger condition present on the arm cycle must not fire.
  task automatic arm_pulse();
    rand_side();
    pc_4a    = trig_pc;
    kill_4a  = 1'b1;
    stall_2a = 1'b0;
    arm      = 1'b1;
    step();
    arm      = 1'b0;
  endtask

  task automatic capture_phase(input int stall_mode, input bit pc_seq, input int kill_at,
                               input int budget, input bit need_done);
    int i = 0;
    while ((m_st == 1 || m_st == 2) && i < budget) begin
      rand_side();
      stall_2a = (stall_mode == 1) ? 1'(i % 2) : (stall_mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
      pc_4a    = pc_seq ? 32'(4 * i) : 32'h40 + 32'(4 * $urandom_range(0, 7));
      kill_4a  = (kill_at >= 0) ? (i == kill_at) : ($urandom_range(0, 15) == 0);
      step();
      i++;
    end
    if (need_done) check(state_o == 2'b11, "capture_reaches_done", state_o, 2'b11);
  endtask

  task automatic readout_phase(input int budget, input bit always_req, input bit need_idle);
    int i = 0;
    while (m_st == 3 && i < budget) begin
      rand_side();
      rd_req = always_req ? 1'b1 : ($urandom_range(0, 9) < 7);
      step();
      i++;
    end
    if (need_idle) check(state_o == 2'b00, "readout_returns_idle", state_o, 2'b00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst_b = 1'b0; arm = 1'b0; trig_pc_en = 1'b0; trig_pc = '0; trig_kill_en = 1'b0;
    post_len = '0; pc_1a = '0; pc_4a = '0; kill_4a = 1'b0; stall_2a = 1'b0;
    st__push_5a = 1'b0; st__to_push_5a = '0; rd_req = 1'b0;
    model_reset();
    #23;
    check(state_o == 2'b00, "reset_state", state_o, 0);
    check(rd_valid == 1'b0, "reset_rd_valid", rd_valid, 0);
    check(rd_last == 1'b0, "reset_rd_last", rd_last, 0);
    check(wrapped == 1'b0, "reset_wrapped", wrapped, 0);
    check(trig_idx == '0, "reset_trig_idx", trig_idx, 0);
    check(rd_data == '0, "reset_rd_data", rd_data, 0);
    rst_b = 1'b1;
    @(posedge clk); #1;

    repeat (3) begin rand_side(); rd_req = 1'b1; step(); end

    // PC-match trigger, sequential PCs, wraps
    trig_pc_en = 1'b1; trig_pc = 32'h40; trig_kill_en = 1'b0; post_len = 5'd3;
    arm_pulse();
    n0 = n_rd;
    capture_phase(0, 1, -1, 64, 1);
    check(trig_idx == 4'd0, "t1_trig_idx", trig_idx, 0);
    check(wrapped == 1'b1, "t1_wrapped", wrapped, 1);
    readout_phase(64, 1, 1);
    check(n_rd - n0 == 16, "t1_read_count", n_rd - n0, 16);

    // kill trigger on third capture, no post window
    trig_pc_en = 1'b0; trig_kill_en = 1'b1; post_len = 5'd0;
    arm_pulse();
    n0 = n_rd;
    capture_phase(0, 1, 2, 64, 1);
    check(wrapped == 1'b0, "t2_wrapped", wrapped, 0);
    readout_phase(64, 0, 1);
    check(n_rd - n0 == 3, "t2_read_count", n_rd - n0, 3);

    // alternate stalls
    post_len = 5'd2;
    arm_pulse();
    n0 = n_rd;
    capture_phase(1, 1, 4, 64, 1);
    readout_phase(64, 0, 1);
    check(n_rd - n0 == 5, "t3_read_count", n_rd - n0, 5);

    // post_len clamp
    post_len = 5'd31;
    arm_pulse();
    n0 = n_rd;
    capture_phase(0, 1, 5, 64, 1);
    check(trig_idx == 4'd5, "t4_trig_idx", trig_idx, 5);
    readout_phase(64, 1, 1);
    check(n_rd - n0 == 16, "t4_read_count", n_rd - n0, 16);

    // re-arm mid-POST and mid-readout
    post_len = 5'd10;
    arm_pulse();
    capture_phase(0, 0, 2, 5, 0);
    check(state_o == 2'b10, "t5_in_post", state_o, 2'b10);
    arm_pulse();
    check(state_o == 2'b01, "t5_rearm_post", state_o, 2'b01);
    capture_phase(0, 0, 2, 64, 1);
    readout_phase(3, 1, 0);
    arm_pulse();
    check(rd_valid == 1'b0, "t5_rd_valid_after_arm", rd_valid, 0);
    n0 = n_rd;
    capture_phase(0, 0, 2, 64, 1);
    readout_phase(64, 0, 1);
    check(n_rd - n0 == 13, "t5_read_count", n_rd - n0, 13);

    // async reset mid-POST
    arm_pulse();
    capture_phase(0, 0, 2, 5, 0);
    #3 rst_b = 1'b0;
    #1;
    check(state_o == 2'b00, "t6_state", state_o, 0);
    check(rd_valid == 1'b0, "t6_rd_valid", rd_valid, 0);
    check(rd_last == 1'b0, "t6_rd_last", rd_last, 0);
    check(wrapped == 1'b0, "t6_wrapped", wrapped, 0);
    check(trig_idx == '0, "t6_trig_idx", trig_idx, 0);
    check(rd_data == '0, "t6_rd_data", rd_data, 0);
    model_reset();
    @(posedge clk); #3 rst_b = 1'b1;
    @(posedge clk); #1;
    repeat (4) begin
      rand_side(); rd_req = 1'b1; step();
      check(rd_valid == 1'b0, "t6_rd_req_before_arm", rd_valid, 0);
    end

    // randomized trigger configurations
    repeat (15) begin
      int mode;
      mode         = $urandom_range(1, 3);
      trig_pc      = 32'h40 + 32'(4 * $urandom_range(0, 7));
      trig_pc_en   = 1'(mode % 2);
      trig_kill_en = 1'(mode / 2);
      post_len     = 5'($urandom_range(0, 31));
      arm_pulse();
      capture_phase(2, 0, -1, 400, 1);
      readout_phase(200, 0, 1);
    end

    rd_req = 1'b0;
    @(negedge clk);
    check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
